// File: rtl/msk_unshare_pkg.sv
// msk_unshare_pkg
// Shared definitions for the sequential share-recombination receiver.
//   - state_e      : controller state encoding (IDLE=0, ACCUM=1, OUT=2)
//   - cnt_width()  : width of the share counter for a given share count
//   - share_idx()  : position of share i of bit j in the bit-sliced bus
package msk_unshare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Counter only has to reach d-1, so $clog2(d) bits are enough.
  function automatic int cnt_width(input int d);
    return $clog2(d);
  endfunction

  // Bit-sliced layout: all d shares of bit j sit next to each other.
  function automatic int share_idx(input int bit_j, input int share_i, input int d);
    return bit_j * d + share_i;
  endfunction

endpackage

// File: rtl/msk_unshare_ctrl.sv
// msk_unshare_ctrl
// Controller for msk_unshare_seq: FSM, share counter, handshake outputs.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid        : sharing offered by the source
//   out_ready       : sink accepts the recombined word
//   in_ready        : a sharing can be accepted this cycle
//   out_valid       : recombined word is presented
//   busy            : controller is in ACCUM or OUT
//   load            : acceptance edge (register shares, seed accumulator)
//   fold            : fold share[cnt] into the accumulator at this edge
//   last_fold       : the share being folded is share d-1
//   out_fire        : output handshake completes at this edge
//   cnt             : index of the share to fold next
//   state_o         : current FSM state (debug)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready/out_valid never depend combinationally on in_valid or
// out_ready, and out_valid, once raised, stays up until the handshake.
module msk_unshare_ctrl
  import msk_unshare_pkg::*;
#(
  parameter int D  = 2,
  parameter int CW = cnt_width(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          busy,
  output logic          load,
  output logic          fold,
  output logic          last_fold,
  output logic          out_fire,
  output logic [CW-1:0] cnt,
  output logic [1:0]    state_o
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Holds in_ready low for the first cycle after reset is released.
  logic          rdy_en_q, rdy_en_d;

  assign rdy_en_d = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    fold      = 1'b0;
    last_fold = 1'b0;
    out_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = rdy_en_q;
        if (in_valid && rdy_en_q) begin
          load    = 1'b1;
          cnt_d   = CW'(1);
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        busy = 1'b1;
        fold = 1'b1;
        if (cnt_q == CW'(D - 1)) begin
          // Counter holds at d-1; it is reloaded on the next acceptance.
          last_fold = 1'b1;
          state_d   = ST_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt     = cnt_q;
  assign state_o = state_q;

endmodule

// File: rtl/msk_unshare_seq.sv
// msk_unshare_seq
// Sequential unmasking receiver: accepts one d-share, nbits-wide sharing
// (bit-sliced, share i of bit j at index j*d+i), folds one share per cycle
// into an accumulator and presents the plaintext on a valid/ready output.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : sharing offered on in_shares
//   in_ready   : block can accept a sharing this cycle
//   in_shares  : d*nbits bit-sliced sharing, sampled only at acceptance
//   out_valid  : out_data holds a recombined word
//   out_ready  : sink accepts out_data this cycle
//   out_data   : unmasked word (XOR of all shares per bit)
//   busy       : high while recombining or presenting a word
// Build option:
//   MSK_UNSHARE_WIPE_EN : clear the share register when the last share has
//   been folded, and clear accumulator/out_data at the output handshake.
//   Without it the registers keep their last contents. Timing is identical.
module msk_unshare_seq
  import msk_unshare_pkg::*;
#(
  parameter int d     = 2,
  parameter int nbits = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [d*nbits-1:0] in_shares,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [nbits-1:0]   out_data,
  output logic               busy
);

  localparam int CW = cnt_width(d);

  logic          load;
  logic          fold;
  logic          last_fold;
  logic          out_fire;
  logic [CW-1:0] cnt;
  logic [1:0]    dbg_state;

  msk_unshare_ctrl #(
    .D  (d),
    .CW (CW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .load      (load),
    .fold      (fold),
    .last_fold (last_fold),
    .out_fire  (out_fire),
    .cnt       (cnt),
    .state_o   (dbg_state)
  );

  logic [d*nbits-1:0] share_q, share_d;
  logic [nbits-1:0]   acc_q, acc_d;
  logic [nbits-1:0]   share0;
  logic [nbits-1:0]   share_sel;

  // Share 0 of every bit seeds the accumulator; share[cnt] is the single
  // share XORed in per cycle, so no path combines more than two shares.
  always_comb begin
    share0    = '0;
    share_sel = '0;
    for (int j = 0; j < nbits; j++) begin
      share0[j]    = in_shares[share_idx(j, 0, d)];
      share_sel[j] = share_q[share_idx(j, int'(cnt), d)];
    end
  end

  always_comb begin
    share_d = share_q;
    acc_d   = acc_q;
    if (load) begin
      share_d = in_shares;
      acc_d   = share0;
    end else if (fold) begin
      acc_d = acc_q ^ share_sel;
`ifdef MSK_UNSHARE_WIPE_EN
      if (last_fold) begin
        share_d = '0;
      end
`endif
    end
`ifdef MSK_UNSHARE_WIPE_EN
    else if (out_fire) begin
      acc_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      share_q <= '0;
      acc_q   <= '0;
    end else begin
      share_q <= share_d;
      acc_q   <= acc_d;
    end
  end

  assign out_data = acc_q;

  // Observed only hierarchically or by the wipe logic.
  logic unused_sigs;
  assign unused_sigs = ^{dbg_state, last_fold, out_fire};

endmodule

// File: tb/tb_msk_unshare_seq.sv
// tb_msk_unshare_seq
// Bench for msk_unshare_seq with two instances (d=2 and d=3, nbits=8).
// A select variable routes the handshake to one instance at a time.
// Build option MSK_UNSHARE_WIPE_EN switches the post-handshake checks.
module tb_msk_unshare_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   sel;
  logic in_valid;
  logic out_ready;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [15:0] in_shares2;
  logic [7:0]  out_data2;
  logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [23:0] in_shares3;
  logic [7:0]  out_data3;

  assign in_valid2  = in_valid && (sel == 2);
  assign out_ready2 = out_ready && (sel == 2);
  assign in_valid3  = in_valid && (sel == 3);
  assign out_ready3 = out_ready && (sel == 3);

  logic       cur_in_ready, cur_out_valid, cur_busy;
  logic [7:0] cur_out_data;
  assign cur_in_ready  = (sel == 3) ? in_ready3  : in_ready2;
  assign cur_out_valid = (sel == 3) ? out_valid3 : out_valid2;
  assign cur_busy      = (sel == 3) ? busy3      : busy2;
  assign cur_out_data  = (sel == 3) ? out_data3  : out_data2;

  msk_unshare_seq #(.d(2), .nbits(8)) u_d2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_shares (in_shares2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .busy      (busy2)
  );

  msk_unshare_seq #(.d(3), .nbits(8)) u_d3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_shares (in_shares3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .busy      (busy3)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks;
  int n_pass;
  int cyc;
  logic [7:0] exp_q[$];
  int         out_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Samples between the input-drive negedge and the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst && cur_out_valid && out_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("sb_out_data", 32'(cur_out_data), 32'(e));
      end
      out_t.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_shares(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    logic [7:0] sh[3];
    sh[0] = s0; sh[1] = s1; sh[2] = s2;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 2; i++) in_shares2[j*2+i] = sh[i][j];
      for (int i = 0; i < 3; i++) in_shares3[j*3+i] = sh[i][j];
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cur_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", 32'(cur_in_ready), 32'd1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!cur_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 32'(cur_out_valid), 32'd1);
  endtask

  // Full transaction: accept, check latency, optional stall, handshake.
  task automatic send_one(input int dd, input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] ex, input int stall);
    int n;
    sel = dd;
    wait_ready();
    set_shares(s0, s1, s2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(ex);
    chk("busy_after_accept", 32'(cur_busy), 32'd1);
    chk("in_ready_in_accum", 32'(cur_in_ready), 32'd0);
    wait_out(n);
    chk("latency", 32'(n), 32'(dd - 1));
    chk("out_data", 32'(cur_out_data), 32'(ex));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(cur_out_valid), 32'd1);
      chk("stall_data", 32'(cur_out_data), 32'(ex));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_hs", 32'(cur_out_valid), 32'd0);
    chk("ready_after_hs", 32'(cur_in_ready), 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int         dd;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] ex;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words[4];
    int n;
    int tries;
    logic accepted;

    tbl[0] = '{2, 8'h3C, 8'h99, 8'h00, 8'hA5};
    tbl[1] = '{3, 8'h5A, 8'h0F, 8'h55, 8'h00};
    tbl[2] = '{3, 8'hFF, 8'h00, 8'h0F, 8'hF0};
    tbl[3] = '{2, 8'h01, 8'h01, 8'h00, 8'h00};
    tbl[4] = '{3, 8'h80, 8'h40, 8'h20, 8'hE0};

    n_checks = 0; n_pass = 0; cyc = 0;
    sel = 2; in_valid = 1'b0; out_ready = 1'b0;
    set_shares(8'h0, 8'h0, 8'h0);

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid2", 32'(out_valid2), 32'd0);
    chk("rst_out_data2", 32'(out_data2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_in_ready2", 32'(in_ready2), 32'd0);
    chk("rst_in_ready3", 32'(in_ready3), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_right_after_rst", 32'(in_ready2), 32'd0);
    @(negedge clk);
    chk("in_ready_cycle_after_rst", 32'(in_ready2), 32'd1);

    // Table-driven transactions
    for (int k = 0; k < 5; k++)
      send_one(tbl[k].dd, tbl[k].s0, tbl[k].s1, tbl[k].s2, tbl[k].ex, 0);

    // Post-handshake register contents for 0xA5
    send_one(2, 8'h3C, 8'h99, 8'h00, 8'hA5, 0);
`ifdef MSK_UNSHARE_WIPE_EN
    chk("wipe_share_q", 32'(u_d2.share_q), 32'd0);
    chk("wipe_acc_q", 32'(u_d2.acc_q), 32'd0);
    chk("wipe_out_data", 32'(out_data2), 32'd0);
`else
    chk("hold_out_data_idle", 32'(out_data2), 32'hA5);
`endif

    // Backpressure with a second word waiting
    sel = 2;
    wait_ready();
    set_shares(8'h3C, 8'h99, 8'h00);
    in_valid = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hA5);
    set_shares(8'h12, 8'h34, 8'h00);
    wait_out(n);
    for (int s = 0; s < 5; s++) begin
      chk("bp_valid", 32'(cur_out_valid), 32'd1);
      chk("bp_data", 32'(cur_out_data), 32'hA5);
      chk("bp_in_ready", 32'(cur_in_ready), 32'd0);
      @(negedge clk);
    end
    exp_q.push_back(8'h26);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_valid_after_hs", 32'(cur_out_valid), 32'd0);
    chk("bp_in_ready_after_hs", 32'(cur_in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", 32'(cur_busy), 32'd1);
    wait_out(n);
    chk("bp_second_data", 32'(cur_out_data), 32'h26);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-to-back, out_ready held high, d=2
    sel = 2;
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF; words[3] = 8'h00;
    out_t.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] r;
      r = 8'($urandom);
      set_shares(r, r ^ words[k], 8'h00);
      in_valid = 1'b1;
      exp_q.push_back(words[k]);
      tries = 0;
      do begin
        accepted = cur_in_ready;
        @(negedge clk);
        tries++;
      end while (!accepted && tries < 20);
      chk("b2b_accepted", 32'(accepted), 32'd1);
    end
    in_valid = 1'b0;
    tries = 0;
    while (exp_q.size() != 0 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    out_ready = 1'b0;
    chk("b2b_outputs", 32'(out_t.size()), 32'd4);
    for (int k = 1; k < 4 && k < out_t.size(); k++)
      chk("b2b_spacing", 32'(out_t[k] - out_t[k-1]), 32'd3);

    // Randomized sharings against the XOR reference model
    for (int dd = 2; dd <= 3; dd++) begin
      for (int k = 0; k < 12; k++) begin
        logic [7:0] s0, s1, s2, ex;
        s0 = 8'($urandom);
        s1 = 8'($urandom);
        s2 = (dd == 3) ? 8'($urandom) : 8'h00;
        ex = s0 ^ s1 ^ s2;
        send_one(dd, s0, s1, s2, ex, $urandom_range(0, 3));
      end
    end

    // Reset in the middle of ACCUM, d=3: word is dropped
    sel = 3;
    wait_ready();
    set_shares(8'h5A, 8'h0F, 8'h55);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid3), 32'd0);
    chk("mid_rst_out_data", 32'(out_data3), 32'd0);
    chk("mid_rst_busy", 32'(busy3), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready3), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_low", 32'(in_ready3), 32'd0);
    @(negedge clk);
    chk("mid_rst_ready_high", 32'(in_ready3), 32'd1);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("mid_rst_no_output", 32'(out_valid3), 32'd0);
    end

    // Recovery after reset
    send_one(3, 8'hFF, 8'h00, 8'h0F, 8'hF0, 1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/msk_unshare_seq.md
Name: msk_unshare_seq

Overview:
- Sequential unmasking (share recombination) receiver. It sits at the output boundary of a masked datapath built from MSK gadgets, where d-share sharings leave the masked domain.
- Accepts one nbits-wide d-share sharing over a valid/ready handshake. Recombines it by XOR-folding one share per cycle into an accumulator, then presents the plaintext word on a valid/ready output.
- It is the counterpart of the sharing/encoding side: masked gadgets consume and produce sharings, and this block turns a sharing back into clear data.

Parameters:
- d, 2, number of shares; legal range d >= 2.
- nbits, 8, number of bits per masked word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a sharing is offered on in_shares.
- in_ready  output  1  block can accept a sharing this cycle.
- in_shares  input  d*nbits  masked word, bit-sliced; share i of bit j is at index j*d+i.
- out_valid  output  1  out_data holds a recombined word.
- out_ready  input  1  sink accepts out_data this cycle.
- out_data  output  nbits  unmasked word, bit j = XOR over i of share i of bit j.
- busy  output  1  high in ACCUM or OUT.

Behaviour:
- Reset: asynchronous, active-high. While rst=1: state=IDLE, share register=0, accumulator=0, counter=0, out_valid=0, out_data=0, busy=0, in_ready=0. After rst falls, in_ready=1 from the next cycle.
- Reset mid-operation discards the in-flight word; no output is produced for it.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: register in_shares; accumulator <= share 0 of every bit; counter <= 1; go to ACCUM.
- State ACCUM:
  - in_ready=0.
  - Each edge: accumulator ^= share[counter] (all bits in parallel); counter++.
  - When the share just folded is share d-1, go to OUT.
  - Exactly one share is combined per cycle; no combinational path XORs more than two shares.
- State OUT:
  - out_valid=1; out_data = accumulator.
  - out_data is stable while out_valid=1 and out_ready=0.
  - On out_ready=1 at an edge: go to IDLE; out_valid falls.
- Latency: accept edge at cycle 0 -> out_valid=1 after edge d-1 (d=2: 1 cycle; d=3: 2 cycles).
- Throughput: one word per d+1 cycles when out_ready is held at 1.
- Simultaneous events: in_ready=0 in OUT, so a new in_valid during the output handshake cycle is not accepted. Earliest acceptance is the following cycle, in IDLE.
- in_valid while not in IDLE is ignored; the source must hold it.
- in_shares is sampled only at the acceptance edge; later changes have no effect.
- Counter width is $clog2(d). It never wraps, because it is reloaded at every acceptance.
- out_data holds its last value in IDLE. It is meaningful only while out_valid=1.

Optional Feature:
- Macro MSK_UNSHARE_WIPE_EN.
- Defined:
  - The share register is cleared to 0 on the ACCUM->OUT transition.
  - The accumulator and out_data are cleared to 0 on the OUT->IDLE handshake edge.
  - Each wipe adds no cycles.
- Undefined: registers retain their last contents; latency and throughput are identical.

Decomposition:
- Package msk_unshare_pkg:
  - state encoding (IDLE=0, ACCUM=1, OUT=2, 2-bit);
  - function for counter width ($clog2(d));
  - index helper for the bit-sliced share layout.
- One sub-module: msk_unshare_ctrl, containing the FSM, share counter, handshake outputs and busy. The datapath (share register, XOR fold, accumulator) stays in the top module.

Test Plan:
- Basic d=2, nbits=8: shares s0=0x3C, s1=0x99, out_ready=1 -> out_valid one cycle after acceptance, out_data=0xA5, in_ready back to 1 the cycle after the handshake.
- d=3: shares 0x5A, 0x0F, 0x55 -> out_data=0x00 two cycles after acceptance; d=3 with 0xFF, 0x00, 0x0F -> 0xF0.
- Backpressure, d=2: 0x3C/0x99 with out_ready=0 for 5 cycles -> out_valid=1 and out_data=0xA5 stable throughout. A second in_valid during this time is not accepted (in_ready=0). It is accepted in the cycle after out_ready rises.
- Back-to-back with out_ready=1: 4 words (0x01, 0x80, 0xFF, 0x00, random share splits) -> outputs in order with correct values, one every 3 cycles for d=2.
- Reset mid-ACCUM (d=3, assert rst one cycle after acceptance) -> out_valid=0, out_data=0, busy=0 immediately. No output for the aborted word; in_ready=1 the cycle after rst falls.
- With MSK_UNSHARE_WIPE_EN: after the handshake of 0xA5, internal share register, accumulator and out_data read 0. Without the macro, out_data still reads 0xA5 in IDLE.
